// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile
//   Oversampled I2C target (7-bit address, repeated START, burst read/write with
//   auto-incrementing pointer) in front of an 8-bit register file that local
//   logic can also reach through a parallel host port.
// Ports
//   clk, rst_n          system clock (>= 8x SCL), async active-low reset
//   scl_i, sda_i        raw pad inputs (asynchronous)
//   sda_oe              1 = pull SDA low (open drain, never driven high)
//   host_we/addr/wdata  host write port; host_rdata = reg[host_addr] (comb)
//   wr_strobe, wr_addr  one-cycle pulse + index of each I2C register commit
//   busy                address-matched START seen, cleared by STOP
module i2c_slave_regfile #(
   parameter logic [6:0] SLAVE_ADDR = 7'h2A,
   parameter int         NUM_REGS   = 16,
   parameter int         FILT_LEN   = 3,
   localparam int        PW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe,
   input  logic          host_we,
   input  logic [PW-1:0] host_addr,
   input  logic [7:0]    host_wdata,
   output logic [7:0]    host_rdata,
   output logic          wr_strobe,
   output logic [PW-1:0] wr_addr,
   output logic          busy
);

   localparam logic [8:0]    NREGS_W = 9'(NUM_REGS);
   localparam logic [PW:0]   NREGS_P = (PW+1)'(NUM_REGS);
   localparam logic [PW-1:0] PTR_MAX = PW'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADDR     = 3'd1,
      S_ADDR_ACK = 3'd2,
      S_WR_BYTE  = 3'd3,
      S_WR_ACK   = 3'd4,
      S_RD_BYTE  = 3'd5,
      S_RD_ACK   = 3'd6,
      S_IGNORE   = 3'd7
   } state_t;

   // input conditioning
   logic [1:0]          scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic [FILT_LEN-1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
   logic [FILT_LEN:0]   scl_ext_s, sda_ext_s;
   logic                scl_lvl_q, scl_lvl_d, sda_lvl_q, sda_lvl_d;
   logic                scl_prev_q, sda_prev_q;
   logic                scl_r_s, scl_f_s, sda_r_s, sda_f_s, start_s, stop_s;

   // protocol engine
   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    shift_q, shift_d, byte_s;
   logic [PW-1:0] ptr_q, ptr_d, ptr_inc_s;
   logic          ptr_phase_q, ptr_phase_d;
   logic          sda_oe_q, sda_oe_d, busy_q, busy_d;
   logic          wr_strobe_q, wr_strobe_d, commit_s;
   logic [PW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    regs_q [NUM_REGS];
   logic [7:0]    regs_d [NUM_REGS];

   // Synchroniser shift, sample history, and a level that moves only once the
   // whole history agrees; otherwise the previous level is held.
   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl_i};
      sda_sync_d = {sda_sync_q[0], sda_i};
      scl_ext_s  = {scl_hist_q, scl_sync_q[1]};
      sda_ext_s  = {sda_hist_q, sda_sync_q[1]};
      scl_hist_d = scl_ext_s[FILT_LEN-1:0];
      sda_hist_d = sda_ext_s[FILT_LEN-1:0];
      if (&scl_hist_q)       scl_lvl_d = 1'b1;
      else if (~|scl_hist_q) scl_lvl_d = 1'b0;
      else                   scl_lvl_d = scl_lvl_q;
      if (&sda_hist_q)       sda_lvl_d = 1'b1;
      else if (~|sda_hist_q) sda_lvl_d = 1'b0;
      else                   sda_lvl_d = sda_lvl_q;
   end

   assign scl_r_s = scl_lvl_q & ~scl_prev_q;
   assign scl_f_s = ~scl_lvl_q & scl_prev_q;
   assign sda_r_s = sda_lvl_q & ~sda_prev_q;
   assign sda_f_s = ~sda_lvl_q & sda_prev_q;
   assign start_s = sda_f_s & scl_lvl_q;
   assign stop_s  = sda_r_s & scl_lvl_q;

   assign byte_s    = {shift_q[6:0], sda_lvl_q};
   assign ptr_inc_s = (ptr_q == PTR_MAX) ? {PW{1'b0}} : ptr_q + 1'b1;

   // Protocol FSM. SDA is sampled on scl_r; sda_oe is only re-decided on scl_f
   // so the pad changes while SCL is low. START/STOP override every state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      ptr_phase_d = ptr_phase_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      commit_s    = 1'b0;
      if (start_s) begin
         state_d  = S_ADDR;
         cnt_d    = 3'd7;
         sda_oe_d = 1'b0;
      end else if (stop_s) begin
         state_d  = S_IDLE;
         busy_d   = 1'b0;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               sda_oe_d = 1'b0;
            end
            S_ADDR: begin
               if (scl_r_s) begin
                  shift_d = byte_s;
                  if (cnt_q == 3'd0) begin
                     if (byte_s[7:1] == SLAVE_ADDR) begin
                        state_d = S_ADDR_ACK;
                        busy_d  = 1'b1;
                     end else begin
                        state_d = S_IGNORE;
                     end
                  end else begin
                     cnt_d = cnt_q - 3'd1;
                  end
               end else begin
                  shift_d = shift_q;
               end
            end
            S_ADDR_ACK: begin
               // shift_q[0] still holds the R/W bit of the address byte
               if (scl_f_s) begin
                  sda_oe_d = 1'b1;
               end else if (scl_r_s) begin
                  cnt_d = 3'd7;
                  if (shift_q[0]) begin
                     shift_d = regs_q[ptr_q];
                     state_d = S_RD_BYTE;
                  end else begin
                     ptr_phase_d = 1'b1;
                     state_d     = S_WR_BYTE;
                  end
               end else begin
                  state_d = S_ADDR_ACK;
               end
            end
            S_WR_BYTE: begin
               if (scl_f_s) begin
                  sda_oe_d = 1'b0;
               end else if (scl_r_s) begin
                  shift_d = byte_s;
                  if (cnt_q != 3'd0) begin
                     cnt_d = cnt_q - 3'd1;
                  end else if (ptr_phase_q) begin
                     // out-of-range pointer: leave SDA released (NACK)
                     if ({1'b0, byte_s} >= NREGS_W) begin
                        state_d = S_IGNORE;
                     end else begin
                        ptr_d       = byte_s[PW-1:0];
                        ptr_phase_d = 1'b0;
                        state_d     = S_WR_ACK;
                     end
                  end else begin
                     commit_s = 1'b1;
                     ptr_d    = ptr_inc_s;
                     state_d  = S_WR_ACK;
                  end
               end else begin
                  state_d = S_WR_BYTE;
               end
            end
            S_WR_ACK: begin
               if (scl_f_s) begin
                  sda_oe_d = 1'b1;
               end else if (scl_r_s) begin
                  cnt_d   = 3'd7;
                  state_d = S_WR_BYTE;
               end else begin
                  state_d = S_WR_ACK;
               end
            end
            S_RD_BYTE: begin
               if (scl_f_s) begin
                  sda_oe_d = ~shift_q[7];
               end else if (scl_r_s) begin
                  if (cnt_q == 3'd0) begin
                     state_d = S_RD_ACK;
                  end else begin
                     cnt_d   = cnt_q - 3'd1;
                     shift_d = {shift_q[6:0], 1'b0};
                  end
               end else begin
                  state_d = S_RD_BYTE;
               end
            end
            S_RD_ACK: begin
               if (scl_f_s) begin
                  sda_oe_d = 1'b0;
               end else if (scl_r_s) begin
                  if (sda_lvl_q == 1'b0) begin
                     ptr_d   = ptr_inc_s;
                     shift_d = regs_q[ptr_inc_s];
                     cnt_d   = 3'd7;
                     state_d = S_RD_BYTE;
                  end else begin
                     state_d = S_IGNORE;
                  end
               end else begin
                  state_d = S_RD_ACK;
               end
            end
            S_IGNORE: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               state_d  = S_IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   // Register file update: host first, then the I2C commit, so a same-index
   // collision keeps the I2C byte while different indices both land.
   always_comb begin
      regs_d = regs_q;
      if (host_we && ({1'b0, host_addr} < NREGS_P)) begin
         regs_d[host_addr] = host_wdata;
      end else begin
         regs_d = regs_q;
      end
      if (commit_s) begin
         regs_d[ptr_q] = byte_s;
      end else begin
         regs_d = regs_d;
      end
      wr_strobe_d = commit_s;
      wr_addr_d   = commit_s ? ptr_q : wr_addr_q;
   end

   // State and datapath registers; bus inputs reset to the idle-high level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q  <= 2'b11;
         sda_sync_q  <= 2'b11;
         scl_hist_q  <= {FILT_LEN{1'b1}};
         sda_hist_q  <= {FILT_LEN{1'b1}};
         scl_lvl_q   <= 1'b1;
         sda_lvl_q   <= 1'b1;
         scl_prev_q  <= 1'b1;
         sda_prev_q  <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= 3'd7;
         shift_q     <= 8'h00;
         ptr_q       <= {PW{1'b0}};
         ptr_phase_q <= 1'b0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= {PW{1'b0}};
         regs_q      <= '{default: 8'h00};
      end else begin
         scl_sync_q  <= scl_sync_d;
         sda_sync_q  <= sda_sync_d;
         scl_hist_q  <= scl_hist_d;
         sda_hist_q  <= sda_hist_d;
         scl_lvl_q   <= scl_lvl_d;
         sda_lvl_q   <= sda_lvl_d;
         scl_prev_q  <= scl_lvl_q;
         sda_prev_q  <= sda_lvl_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         ptr_phase_q <= ptr_phase_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         regs_q      <= regs_d;
      end
   end

   assign sda_oe     = sda_oe_q;
   assign busy       = busy_q;
   assign wr_strobe  = wr_strobe_q;
   assign wr_addr    = wr_addr_q;
   assign host_rdata = ({1'b0, host_addr} < NREGS_P) ? regs_q[host_addr] : 8'h00;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Testbench for i2c_slave_regfile: bit-banged I2C master on an open-drain bus,
// host-port vector table, and queues of expected read bytes / commit indices.
module tb_i2c_slave_regfile;

   localparam int PW = 4;
   localparam int Q  = 12;   // clk cycles per quarter SCL period

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          scl_m = 1'b1;
   logic          sda_m = 1'b1;
   logic          sda_line;
   logic          sda_oe;
   logic          host_we = 1'b0;
   logic [PW-1:0] host_addr = '0;
   logic [7:0]    host_wdata = 8'h00;
   logic [7:0]    host_rdata;
   logic          wr_strobe;
   logic [PW-1:0] wr_addr;
   logic          busy;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]    rd_exp_q[$];
   logic [PW-1:0] wr_exp_q[$];
   logic [PW-1:0] obs_wr [256];
   int            obs_cnt = 0;
   int            obs_idx = 0;
   int            oe_cnt = 0;

   assign sda_line = sda_m & ~sda_oe;

   i2c_slave_regfile #(.SLAVE_ADDR(7'h2A), .NUM_REGS(16), .FILT_LEN(3)) dut (
      .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   // record every commit index and every cycle SDA is pulled
   always @(negedge clk) begin
      if (wr_strobe) begin
         obs_wr[obs_cnt[7:0]] <= wr_addr;
         obs_cnt <= obs_cnt + 1;
      end
      if (sda_oe) oe_cnt <= oe_cnt + 1;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic bit_xfer(input logic b, input logic glitch, output logic s);
      wait_q();
      sda_m = b;
      if (glitch) begin
         scl_m = 1'b1;
         @(posedge clk); #1;
         scl_m = 1'b0;
      end
      wait_q();
      scl_m = 1'b1;
      wait_q();
      s = sda_line;
      wait_q();
      scl_m = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], (i == gbit), s);
      bit_xfer(1'b1, 1'b0, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, 1'b0, s);
         d[i] = s;
      end
      bit_xfer(mack, 1'b0, s);
   endtask

   task automatic start_cond();
      if (scl_m == 1'b0) begin
         wait_q(); sda_m = 1'b1;
         wait_q(); scl_m = 1'b1;
      end
      wait_q(); sda_m = 1'b0;
      wait_q(); scl_m = 1'b0;
   endtask

   task automatic stop_cond();
      wait_q(); sda_m = 1'b0;
      wait_q(); scl_m = 1'b1;
      wait_q(); sda_m = 1'b1;
      wait_q();
   endtask

   task automatic i2c_wr1(input logic [7:0] ptr, input logic [7:0] dat, input int g,
                          output logic [2:0] acks);
      start_cond();
      write_byte(8'h54, g, acks[2]);
      write_byte(ptr, g, acks[1]);
      write_byte(dat, g, acks[0]);
      stop_cond();
   endtask

   task automatic host_chk(input string nm, input logic [PW-1:0] a, input logic [7:0] exp);
      host_addr = a;
      #1;
      chk(nm, host_rdata, exp);
   endtask

   task automatic rd_chk(input string nm, input logic mack);
      logic [7:0] d;
      logic [7:0] e;
      read_byte(mack, d);
      e = rd_exp_q.pop_front();
      chk(nm, d, e);
   endtask

   // pop expected commit indices against what the monitor observed
   task automatic check_strobes(input string nm);
      logic [PW-1:0] e;
      while (wr_exp_q.size() > 0) begin
         e = wr_exp_q.pop_front();
         if (obs_idx < obs_cnt) begin
            chk(nm, obs_wr[obs_idx[7:0]], e);
            obs_idx++;
         end else begin
            chk({nm, "_missing"}, 32'hDEAD, e);
         end
      end
      chk({nm, "_extra"}, 32'(obs_cnt - obs_idx), 32'd0);
      obs_idx = obs_cnt;
   endtask

   // hold host_we on index ca with changing data until the commit pulse shows
   task automatic collide(input logic [PW-1:0] ca, input logic [7:0] ptr,
                          input logic [7:0] dat, output logic [7:0] last);
      logic [2:0] acks;
      logic       seen;
      seen = 1'b0;
      last = 8'h00;
      fork
         i2c_wr1(ptr, dat, -1, acks);
         begin
            host_addr = ca;
            host_we   = 1'b1;
            for (int c = 0; c < 4000; c++) begin
               host_wdata = 8'(c * 7 + 3);
               last = host_wdata;
               @(posedge clk); #1;
               if (wr_strobe) begin
                  seen = 1'b1;
                  break;
               end
            end
            host_we = 1'b0;
         end
      join
      chk("coll_strobe_seen", seen, 1'b1);
      chk("coll_acks", acks, 3'b000);
   endtask

   typedef struct {
      logic          we;
      logic [PW-1:0] addr;
      logic [7:0]    wdata;
      logic [7:0]    exp;
   } host_vec_t;

   host_vec_t  hv [8];
   logic [2:0] acks;
   logic       a;
   logic [7:0] last;
   int         oe0;

   initial begin
      hv[0] = '{1'b0, 4'd3,  8'h00, 8'h00};
      hv[1] = '{1'b1, 4'd15, 8'hC3, 8'hC3};
      hv[2] = '{1'b1, 4'd0,  8'h81, 8'h81};
      hv[3] = '{1'b1, 4'd1,  8'h7E, 8'h7E};
      hv[4] = '{1'b1, 4'd9,  8'hFF, 8'hFF};
      hv[5] = '{1'b0, 4'd15, 8'h55, 8'hC3};
      hv[6] = '{1'b1, 4'd2,  8'h44, 8'h44};
      hv[7] = '{1'b0, 4'd8,  8'h99, 8'h00};

      // reset values
      repeat (3) @(posedge clk); #1;
      chk("rst_sda_oe", sda_oe, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wr_strobe", wr_strobe, 1'b0);
      chk("rst_wr_addr", wr_addr, 4'd0);
      host_chk("rst_reg15", 4'd15, 8'h00);
      rst_n = 1'b1;
      repeat (10) @(posedge clk); #1;

      // host port table
      for (int i = 0; i < 8; i++) begin
         host_we = hv[i].we; host_addr = hv[i].addr; host_wdata = hv[i].wdata;
         @(posedge clk); #1;
         host_we = 1'b0;
         chk($sformatf("host_vec%0d", i), host_rdata, hv[i].exp);
      end

      // 1: burst write ptr 3, A5 5A
      wr_exp_q.push_back(4'd3); wr_exp_q.push_back(4'd4);
      start_cond();
      write_byte(8'h54, -1, acks[2]);
      chk("t1_busy", busy, 1'b1);
      write_byte(8'h03, -1, acks[1]);
      write_byte(8'hA5, -1, acks[0]);
      write_byte(8'h5A, -1, a);
      chk("t1_acks", {acks, a}, 4'b0000);
      stop_cond();
      chk("t1_busy_stop", busy, 1'b0);
      host_chk("t1_reg3", 4'd3, 8'hA5);
      host_chk("t1_reg4", 4'd4, 8'h5A);
      check_strobes("t1_strobe");

      // 2: ptr 15, repeated START, read 3 with wrap
      start_cond();
      write_byte(8'h54, -1, acks[2]);
      write_byte(8'h0F, -1, acks[1]);
      start_cond();
      write_byte(8'h55, -1, acks[0]);
      chk("t2_acks", acks, 3'b000);
      rd_exp_q.push_back(8'hC3); rd_exp_q.push_back(8'h81); rd_exp_q.push_back(8'h7E);
      rd_chk("t2_rd0", 1'b0);
      rd_chk("t2_rd1", 1'b0);
      rd_chk("t2_rd2", 1'b1);
      chk("t2_oe_after_nack", sda_oe, 1'b0);
      stop_cond();

      // write pointer wrap
      wr_exp_q.push_back(4'd15); wr_exp_q.push_back(4'd0);
      start_cond();
      write_byte(8'h54, -1, acks[2]);
      write_byte(8'h0F, -1, acks[1]);
      write_byte(8'h11, -1, acks[0]);
      write_byte(8'h22, -1, a);
      chk("wrap_acks", {acks, a}, 4'b0000);
      stop_cond();
      host_chk("wrap_reg15", 4'd15, 8'h11);
      host_chk("wrap_reg0", 4'd0, 8'h22);
      check_strobes("wrap_strobe");

      // 3: wrong address
      oe0 = oe_cnt;
      start_cond();
      write_byte(8'h56, -1, acks[1]);
      chk("t3_busy", busy, 1'b0);
      write_byte(8'h03, -1, acks[0]);
      stop_cond();
      chk("t3_nacks", acks[1:0], 2'b11);
      chk("t3_no_oe", 32'(oe_cnt - oe0), 32'd0);
      host_chk("t3_reg3", 4'd3, 8'hA5);
      check_strobes("t3_strobe");

      // 4: pointer out of range
      i2c_wr1(8'h10, 8'h99, -1, acks);
      chk("t4_acks", acks, 3'b011);
      host_chk("t4_reg0", 4'd0, 8'h22);
      check_strobes("t4_strobe");

      // 5: one-cycle SCL glitches while SCL low
      wr_exp_q.push_back(4'd6);
      start_cond();
      write_byte(8'h54, 3, acks[2]);
      write_byte(8'h06, 0, acks[1]);
      write_byte(8'h6B, 5, acks[0]);
      stop_cond();
      chk("t5_acks", acks, 3'b000);
      host_chk("t5_reg6", 4'd6, 8'h6B);
      check_strobes("t5_strobe");

      // collisions: same index then different index
      wr_exp_q.push_back(4'd4);
      collide(4'd4, 8'h04, 8'hE1, last);
      host_chk("coll_same_reg4", 4'd4, 8'hE1);
      check_strobes("coll_same_strobe");
      wr_exp_q.push_back(4'd4);
      collide(4'd5, 8'h04, 8'h3D, last);
      host_chk("coll_diff_reg4", 4'd4, 8'h3D);
      host_chk("coll_diff_reg5", 4'd5, last);
      check_strobes("coll_diff_strobe");

      // 6: reset while driving a read byte
      host_we = 1'b1; host_addr = 4'd7; host_wdata = 8'h12;
      @(posedge clk); #1;
      host_we = 1'b0;
      start_cond();
      write_byte(8'h54, -1, acks[2]);
      write_byte(8'h07, -1, acks[1]);
      start_cond();
      write_byte(8'h55, -1, acks[0]);
      chk("t6_acks", acks, 3'b000);
      wait_q(); wait_q();
      chk("t6_oe_driving", sda_oe, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_oe_async", sda_oe, 1'b0);
      chk("t6_busy_rst", busy, 1'b0);
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b1;
      host_chk("t6_reg7_cleared", 4'd7, 8'h00);
      wait_q(); scl_m = 1'b1;
      wait_q(); sda_m = 1'b1;
      wait_q();
      wr_exp_q.push_back(4'd2);
      i2c_wr1(8'h02, 8'h3C, -1, acks);
      chk("t6_after_acks", acks, 3'b000);
      host_chk("t6_reg2", 4'd2, 8'h3C);
      check_strobes("t6_strobe");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
